// File: rtl/alu_op_sequencer.sv
// Command sequencer for the combinational 16-bit ALU: owns ACC, BR and the flag register,
// drives the one-hot ALU controls for a per-opcode hold time and captures the ALU result.
module alu_op_sequencer #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_code,
   input  logic [15:0] op_data,
   output logic [9:0]  alu_ctrl,
   output logic [15:0] alu_acc,
   output logic [15:0] alu_br,
   input  logic [15:0] alu_result,
   input  logic [3:0]  alu_flags,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_acc,
   output logic [3:0]  res_flags,
   output logic        res_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_MUL  = 4'h4;
   localparam logic [3:0] OP_DIV  = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'hA;
   localparam logic [3:0] OP_LOAD = 4'hB;
   localparam logic [3:0] MUL_LEN = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_LEN = 4'(DIV_CYCLES);

   // One-hot bit order is {C21,C20,C19,C18,C17,C16,C15,C13,C9,C8}; NOP drives no control.
   function automatic logic [9:0] ctrl_decode(input logic [3:0] op);
      case (op)
         4'h1:    ctrl_decode = 10'b00_0000_0001;
         4'h2:    ctrl_decode = 10'b00_0000_0010;
         4'h3:    ctrl_decode = 10'b00_0000_0100;
         4'h4:    ctrl_decode = 10'b00_0000_1000;
         4'h5:    ctrl_decode = 10'b00_0001_0000;
         4'h6:    ctrl_decode = 10'b00_0010_0000;
         4'h7:    ctrl_decode = 10'b00_0100_0000;
         4'h8:    ctrl_decode = 10'b00_1000_0000;
         4'h9:    ctrl_decode = 10'b01_0000_0000;
         4'hA:    ctrl_decode = 10'b10_0000_0000;
         default: ctrl_decode = 10'b00_0000_0000;
      endcase
   endfunction

   function automatic logic [3:0] hold_len(input logic [3:0] op);
      case (op)
         OP_MUL:  hold_len = MUL_LEN;
         OP_DIV:  hold_len = DIV_LEN;
         default: hold_len = 4'd1;
      endcase
   endfunction

   state_t      state_r, state_s;
   logic [3:0]  op_r, op_s;
   logic [3:0]  cnt_r, cnt_s;
   logic [15:0] acc_r, acc_s;
   logic [15:0] br_r, br_s;
   logic [3:0]  flags_r, flags_s;
   logic        err_r, err_s;
   logic [9:0]  ctrl_r, ctrl_s;
   logic        valid_r, valid_s;
   logic        ready_r, ready_s;
   logic        busy_r, busy_s;

   // Next-state and next-value logic; every register holds unless a transition updates it.
   always_comb begin
      state_s = state_r;
      op_s    = op_r;
      cnt_s   = cnt_r;
      acc_s   = acc_r;
      br_s    = br_r;
      flags_s = flags_r;
      err_s   = err_r;
      ctrl_s  = ctrl_r;
      case (state_r)
         IDLE: begin
            if (op_valid && ready_r) begin
               br_s = op_data;
               op_s = op_code;
               if (op_code <= OP_NOT) begin
                  state_s = EXEC;
                  cnt_s   = 4'd1;
                  ctrl_s  = ctrl_decode(op_code);
               end else if (op_code == OP_LOAD) begin
                  acc_s   = op_data;
                  err_s   = 1'b0;
                  state_s = DONE;
               end else begin
                  err_s   = 1'b1;
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_r >= hold_len(op_r)) begin
               state_s = DONE;
               ctrl_s  = 10'd0;
               cnt_s   = 4'd0;
               flags_s = alu_flags;
               // Divide by zero keeps ACC and reports the ALU flags (CF set) as an error.
               if ((op_r == OP_DIV) && (br_r == 16'h0000)) begin
                  err_s = 1'b1;
               end else begin
                  acc_s = alu_result;
                  err_s = 1'b0;
               end
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            ctrl_s  = 10'd0;
            cnt_s   = 4'd0;
         end
      endcase
      valid_s = (state_s == DONE);
      ready_s = (state_s == IDLE);
      busy_s  = (state_s != IDLE);
   end

   // State and output registers; reset drops any in-flight command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         op_r    <= 4'd0;
         cnt_r   <= 4'd0;
         acc_r   <= 16'd0;
         br_r    <= 16'd0;
         flags_r <= 4'd0;
         err_r   <= 1'b0;
         ctrl_r  <= 10'd0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         op_r    <= op_s;
         cnt_r   <= cnt_s;
         acc_r   <= acc_s;
         br_r    <= br_s;
         flags_r <= flags_s;
         err_r   <= err_s;
         ctrl_r  <= ctrl_s;
         valid_r <= valid_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
      end
   end

   assign op_ready  = ready_r;
   assign busy      = busy_r;
   assign alu_ctrl  = ctrl_r;
   assign alu_acc   = acc_r;
   assign alu_br    = br_r;
   assign res_valid = valid_r;
   assign res_acc   = acc_r;
   assign res_flags = flags_r;
   assign res_err   = err_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [3:0]  op_code = 4'h0;
   logic [15:0] op_data = 16'h0000;
   logic [9:0]  alu_ctrl;
   logic [15:0] alu_acc;
   logic [15:0] alu_br;
   logic [15:0] alu_result;
   logic [3:0]  alu_flags;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_acc;
   logic [3:0]  res_flags;
   logic        res_err;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [15:0] acc;
      logic [3:0]  flags;
      logic        err;
   } exp_t;
   exp_t sb[$];

   logic [15:0] m_acc   = 16'h0000;
   logic [3:0]  m_flags = 4'h0;

   alu_op_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_data(op_data), .alu_ctrl(alu_ctrl), .alu_acc(alu_acc),
      .alu_br(alu_br), .alu_result(alu_result), .alu_flags(alu_flags),
      .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc),
      .res_flags(res_flags), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {result, ZF, CF, OF, SF}.
   function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      logic [16:0] w;
      logic [15:0] r;
      logic        c;
      logic        o;
      w = 17'd0; r = a; c = 1'b0; o = 1'b0;
      case (op)
         4'h1: r = 16'h0000;
         4'h2: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                     o = (a[15] == b[15]) && (r[15] != a[15]); end
         4'h3: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                     o = (a[15] != b[15]) && (r[15] != a[15]); end
         4'h4: r = {8'h00, a[7:0]} * {8'h00, b[7:0]};
         4'h5: begin if (b == 16'h0000) begin r = 16'hFFFF; c = 1'b1; end
                     else begin r = a / b; end end
         4'h6: r = a << b[3:0];
         4'h7: r = a >> b[3:0];
         4'h8: r = a & b;
         4'h9: r = a | b;
         4'hA: r = ~a;
         default: r = a;
      endcase
      return {r, (r == 16'h0000), c, o, r[15]};
   endfunction

   function automatic logic [9:0] onehot(input logic [3:0] op);
      logic [9:0] v;
      v = 10'd0;
      if (op >= 4'h1 && op <= 4'hA) v[op - 4'h1] = 1'b1;
      return v;
   endfunction

   logic [3:0] stub_op;
   always_comb begin
      stub_op = 4'h0;
      case (alu_ctrl)
         10'b00_0000_0001: stub_op = 4'h1;
         10'b00_0000_0010: stub_op = 4'h2;
         10'b00_0000_0100: stub_op = 4'h3;
         10'b00_0000_1000: stub_op = 4'h4;
         10'b00_0001_0000: stub_op = 4'h5;
         10'b00_0010_0000: stub_op = 4'h6;
         10'b00_0100_0000: stub_op = 4'h7;
         10'b00_1000_0000: stub_op = 4'h8;
         10'b01_0000_0000: stub_op = 4'h9;
         10'b10_0000_0000: stub_op = 4'hA;
         default:          stub_op = 4'h0;
      endcase
      {alu_result, alu_flags} = alu_fn(stub_op, alu_acc, alu_br);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One command: drive, push expectation, wait for result, optional stall, handshake.
   task automatic run(input logic [3:0] op, input logic [15:0] data, input int stall);
      exp_t e;
      logic [19:0] rf;
      int hold, lat, hc;
      bit bad, seen;
      hold = (op == 4'h4) ? 2 : (op == 4'h5) ? 4 : 1;
      if (op <= 4'hA) begin
         rf = alu_fn(op, m_acc, data);
         e.flags = rf[3:0];
         if (op == 4'h5 && data == 16'h0000) begin e.acc = m_acc; e.err = 1'b1; end
         else begin e.acc = rf[19:4]; e.err = 1'b0; end
      end else if (op == 4'hB) begin
         e.acc = data; e.flags = m_flags; e.err = 1'b0;
      end else begin
         e.acc = m_acc; e.flags = m_flags; e.err = 1'b1;
      end
      m_acc = e.acc; m_flags = e.flags;
      sb.push_back(e);

      @(negedge clk);
      chk("accept_ready", op_ready, 1);
      op_valid = 1'b1; op_code = op; op_data = data;
      @(negedge clk);
      op_valid = 1'b0;
      lat = 0; hc = 0; bad = 0; seen = 0;
      for (int k = 0; k < 40; k++) begin
         lat++;
         if (alu_ctrl != 10'd0) begin
            hc++;
            if (alu_ctrl !== onehot(op) || res_valid) bad = 1;
         end
         if (res_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      chk("res_valid_seen", seen, 1);
      chk("latency", lat, (op <= 4'hA) ? hold + 1 : 1);
      chk("ctrl_hold", hc, (op >= 4'h1 && op <= 4'hA) ? hold : 0);
      chk("ctrl_onehot_exec_only", bad, 0);
      chk("br", alu_br, data);
      for (int s = 0; s < stall; s++) begin
         op_valid = 1'b1; op_code = 4'h2; op_data = 16'h1111;
         @(negedge clk);
         chk("stall_valid", res_valid, 1);
         chk("stall_ready", op_ready, 0);
         chk("stall_acc", res_acc, sb[0].acc);
         chk("stall_br", alu_br, data);
      end
      op_valid = 1'b0;
      e = sb.pop_front();
      chk("res_acc", res_acc, e.acc);
      chk("res_flags", res_flags, e.flags);
      chk("res_err", res_err, e.err);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("idle_after_accept", {op_ready, busy, res_valid}, 3'b100);
   endtask

   initial begin
      bit leaked;
      repeat (3) @(negedge clk);
      chk("rst_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_ctrl", alu_ctrl, 0);
      chk("rst_acc", res_acc, 0);
      chk("rst_flags", res_flags, 0);
      chk("rst_err", res_err, 0);
      chk("rst_br", alu_br, 0);
      rst_n = 1'b1;

      run(4'hB, 16'h7FFF, 0);
      run(4'h2, 16'h0001, 0);
      chk("t1_acc", res_acc, 16'h8000);
      chk("t1_flags", res_flags, 4'b0011);

      run(4'hB, 16'h0064, 0);
      run(4'h5, 16'h0007, 0);
      chk("t2_acc", res_acc, 16'h000E);
      run(4'h5, 16'h0000, 0);
      chk("t2_div0_acc", res_acc, 16'h000E);
      chk("t2_div0_cf", res_flags[2], 1);
      chk("t2_div0_err", res_err, 1);

      run(4'hB, 16'h0012, 0);
      run(4'h4, 16'h0034, 0);
      chk("t3_acc", res_acc, 16'h03A8);

      run(4'hB, 16'h1234, 0);
      run(4'hD, 16'hBEEF, 0);
      chk("t4_acc", res_acc, 16'h1234);
      chk("t4_err", res_err, 1);

      run(4'h1, 16'h5555, 0);
      chk("clr_flags", res_flags, 4'b1000);
      run(4'h0, 16'h0000, 0);
      for (int i = 0; i < 8; i++) begin
         run(4'($urandom_range(0, 10)), 16'($urandom), 0);
      end
      run(4'h6, 16'h0003, 0);
      run(4'h7, 16'h0001, 0);
      run(4'hF, 16'h0000, 0);

      run(4'hB, 16'h0100, 0);
      run(4'h3, 16'h0001, 5);
      chk("t5_acc", res_acc, 16'h00FF);

      @(negedge clk);
      op_valid = 1'b1; op_code = 4'h5; op_data = 16'h0003;
      @(negedge clk);
      op_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_ctrl", alu_ctrl, 0);
      chk("t6_status", {op_ready, busy, res_valid, res_err}, 4'b1000);
      chk("t6_acc", res_acc, 0);
      chk("t6_flags", res_flags, 0);
      chk("t6_br", alu_br, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 16'h0000; m_flags = 4'h0;
      leaked = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (res_valid || busy) leaked = 1;
      end
      chk("t6_no_result", leaked, 0);
      run(4'h2, 16'h0042, 0);
      chk("t6_post_acc", res_acc, 16'h0042);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
